// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// with a +/-pi/2 pre-rotation at capture so the full +/-pi angle range converges.
module cordic_iter #(
  parameter int DATA_W = 20,
  parameter int ANG_W  = 20,
  parameter int ITER   = 16,
  parameter int GUARD  = 2
) (
  input  logic                     CLK_I,
  input  logic                     RST_N_I,
  input  logic                     VALID_I,
  output logic                     READY_O,
  input  logic                     MODE_I,
  input  logic signed [DATA_W-1:0] X_I,
  input  logic signed [DATA_W-1:0] Y_I,
  input  logic signed [ANG_W-1:0]  Z_I,
  output logic                     VALID_O,
  input  logic                     READY_I,
  output logic signed [DATA_W-1:0] X_O,
  output logic signed [DATA_W-1:0] Y_O,
  output logic signed [ANG_W-1:0]  Z_O,
  output logic                     MODE_O
);
  localparam int IW = DATA_W + GUARD;
  localparam int CW = $clog2(ITER);

  function automatic logic signed [ANG_W-1:0] f_ang_q(input real rad);
    real s;
    s = 1.0;
    for (int k = 0; k < ANG_W - 3; k++) s = s * 2.0;
    return ANG_W'($rtoi(rad * s + 0.5));
  endfunction

  // atan(2^-i) by its Taylor series; 2^-i <= 0.5 for i >= 1 so 40 terms are far below 1 LSB.
  function automatic logic signed [ANG_W-1:0] f_atan(input int i);
    real t, t2, term, a, sgn;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    if (i == 0) begin
      a = 0.78539816339744830962;
    end else begin
      a    = 0.0;
      t2   = t * t;
      term = t;
      sgn  = 1.0;
      for (int k = 0; k < 40; k++) begin
        a    = a + sgn * term / $itor(2 * k + 1);
        term = term * t2;
        sgn  = -sgn;
      end
    end
    return f_ang_q(a);
  endfunction

  function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [IW-1:0] v);
    if (v[IW-1:DATA_W-1] == {(GUARD + 1){v[IW-1]}}) return v[DATA_W-1:0];
    else if (v[IW-1]) return {1'b1, {(DATA_W - 1){1'b0}}};
    else return {1'b0, {(DATA_W - 1){1'b1}}};
  endfunction

  localparam logic signed [ANG_W-1:0] PI2 = f_ang_q(1.57079632679489661923);

  logic signed [ANG_W-1:0] w_atan [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [ANG_W-1:0] ATAN_G = f_atan(g);
    assign w_atan[g] = ATAN_G;
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_rdy, r_vld, r_mode, r_fin;
  logic [CW-1:0]           r_cnt;
  logic signed [IW-1:0]    r_x, r_y;
  logic signed [ANG_W-1:0] r_z;

  logic signed [IW-1:0]    w_xe, w_ye, w_x0, w_y0, w_xs, w_ys, w_xn, w_yn;
  logic signed [ANG_W-1:0] w_z0, w_zn;
  logic                    w_up;

  assign w_xe = {{GUARD{X_I[DATA_W-1]}}, X_I};
  assign w_ye = {{GUARD{Y_I[DATA_W-1]}}, Y_I};

  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = Z_I;
    if (!MODE_I) begin
      if (Z_I > PI2) begin
        w_x0 = -w_ye;  w_y0 = w_xe;   w_z0 = Z_I - PI2;
      end else if (Z_I < -PI2) begin
        w_x0 = w_ye;   w_y0 = -w_xe;  w_z0 = Z_I + PI2;
      end
    end else if (X_I[DATA_W-1]) begin
      if (!Y_I[DATA_W-1]) begin
        w_x0 = w_ye;   w_y0 = -w_xe;  w_z0 = Z_I + PI2;
      end else begin
        w_x0 = -w_ye;  w_y0 = w_xe;   w_z0 = Z_I - PI2;
      end
    end
  end

  // One micro-rotation; w_up is d=+1. Both x and y updates use the pre-update values.
  assign w_xs = r_x >>> r_cnt;
  assign w_ys = r_y >>> r_cnt;
  assign w_up = r_mode ? r_y[IW-1] : ~r_z[ANG_W-1];
  assign w_xn = w_up ? r_x - w_ys : r_x + w_ys;
  assign w_yn = w_up ? r_y + w_xs : r_y - w_xs;
  assign w_zn = w_up ? r_z - w_atan[r_cnt] : r_z + w_atan[r_cnt];

  assign READY_O = r_rdy;
  assign VALID_O = r_vld;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
      r_mode  <= 1'b0;
      r_fin   <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      X_O     <= '0;
      Y_O     <= '0;
      Z_O     <= '0;
      MODE_O  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (VALID_I && r_rdy) begin
            r_rdy   <= 1'b0;
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_mode  <= MODE_I;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!r_fin) begin
            r_x <= w_xn;
            r_y <= w_yn;
            r_z <= w_zn;
            if (r_cnt == CW'(ITER - 1)) r_fin <= 1'b1;
            else r_cnt <= r_cnt + 1'b1;
          end else begin
            // Extra cycle after the last iteration: saturate and publish the result.
            X_O     <= f_sat(r_x);
            Y_O     <= f_sat(r_y);
            Z_O     <= r_z;
            MODE_O  <= r_mode;
            r_fin   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (READY_I) begin
            r_vld   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: arithmetic reference model plus a per-cycle output checker.
module tb_cordic_iter;
  localparam int DATA_W = 20;
  localparam int ANG_W  = 20;
  localparam int ITER   = 16;
  localparam int GUARD  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     valid_i, ready_o, mode_i, valid_o, ready_i, mode_o;
  logic signed [DATA_W-1:0] x_i, y_i, x_o, y_o;
  logic signed [ANG_W-1:0]  z_i, z_o;

  cordic_iter #(.DATA_W(DATA_W), .ANG_W(ANG_W), .ITER(ITER), .GUARD(GUARD)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .VALID_I(valid_i), .READY_O(ready_o), .MODE_I(mode_i),
    .X_I(x_i), .Y_I(y_i), .Z_I(z_i), .VALID_O(valid_o), .READY_I(ready_i),
    .X_O(x_o), .Y_O(y_o), .Z_O(z_o), .MODE_O(mode_o)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  longint atan_t [ITER];
  longint pi2;
  logic   exp_vld = 1'b0;
  logic   exp_m = 1'b0;
  logic   first_seen = 1'b0;
  longint exp_x = 0, exp_y = 0, exp_z = 0;
  int     acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint req, input longint tol);
    longint d;
    tests++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    lo = -(longint'(1) <<< (DATA_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model(input logic m, input longint xi, input longint yi, input longint zi,
                                output longint xo, output longint yo, output longint zo);
    longint x, y, z, t;
    logic   up;
    logic signed [ANG_W-1:0] zw;
    x = xi; y = yi; z = zi;
    if (!m && zi > pi2)              begin x = -yi; y = xi;  z = zi - pi2; end
    else if (!m && zi < -pi2)        begin x = yi;  y = -xi; z = zi + pi2; end
    else if (m && xi < 0 && yi >= 0) begin x = yi;  y = -xi; z = zi + pi2; end
    else if (m && xi < 0)            begin x = -yi; y = xi;  z = zi - pi2; end
    for (int i = 0; i < ITER; i++) begin
      up = m ? (y < 0) : (z >= 0);
      t = x;
      if (up) begin x = x - (y >>> i); y = y + (t >>> i); z = z - atan_t[i]; end
      else    begin x = x + (y >>> i); y = y - (t >>> i); z = z + atan_t[i]; end
    end
    xo = sat(x);
    yo = sat(y);
    zw = z[ANG_W-1:0];
    zo = zw;
  endfunction

  // Output checker: every cycle a result is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (!exp_vld) begin
        chk("unexpected_valid", valid_o, 0);
      end else begin
        chk("x_o", x_o, exp_x);
        chk("y_o", y_o, exp_y);
        chk("z_o", z_o, exp_z);
        chk("mode_o", mode_o, exp_m);
        chk("ready_o_in_done", ready_o, 0);
        if (!first_seen) begin
          chk("latency", cyc - acc_cyc, ITER + 1);
          first_seen = 1'b1;
        end
      end
    end
  end

  task automatic accept_txn(input logic m, input longint x, input longint y, input longint z);
    int n;
    longint ex, ey, ez;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < ITER + 10) begin @(negedge clk); n++; end
    chk("ready_before_accept", ready_o, 1);
    mode_i  = m;
    x_i     = x[DATA_W-1:0];
    y_i     = y[DATA_W-1:0];
    z_i     = z[ANG_W-1:0];
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    model(m, x, y, z, ex, ey, ez);
    exp_x = ex; exp_y = ey; exp_z = ez; exp_m = m;
    acc_cyc = cyc;
    first_seen = 1'b0;
    exp_vld = 1'b1;
  endtask

  task automatic finish_txn(input int hold, input logic pulse);
    int n;
    n = 0;
    if (pulse) begin
      repeat (3) @(negedge clk);
      x_i = 20'sd12345; mode_i = ~mode_i; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
    end
    while (!valid_o && n < ITER + 8) begin @(negedge clk); n++; end
    chk("valid_o_seen", valid_o, 1);
    repeat (hold) @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    exp_vld = 1'b0;
    ready_i = 1'b0;
    @(negedge clk);
    chk("valid_o_drop", valid_o, 0);
  endtask

  task automatic txn(input logic m, input longint x, input longint y, input longint z, input int hold);
    accept_txn(m, x, y, z);
    finish_txn(hold, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ex, ey, ez;
    for (int i = 0; i < ITER; i++)
      atan_t[i] = longint'($rtoi($atan(2.0 ** (-i)) * (2.0 ** (ANG_W - 3)) + 0.5));
    pi2 = longint'($rtoi(1.5707963267948966 * (2.0 ** (ANG_W - 3)) + 0.5));

    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; mode_i = 1'b0;
    x_i = '0; y_i = '0; z_i = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready_o", ready_o, 0);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_x_o", x_o, 0);
    chk("rst_y_o", y_o, 0);
    chk("rst_z_o", z_o, 0);
    chk("rst_mode_o", mode_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", ready_o, 1);

    chk("pin_atan0", atan_t[0], 102944);
    chk("pin_pi2", pi2, 205887);

    model(0, 159188, 0, 0, ex, ey, ez);
    chk_near("pin_rot0_x", ex, 262144, 16);
    chk_near("pin_rot0_y", ey, 0, 16);
    chk_near("pin_rot0_z", ez, 0, atan_t[ITER-1]);
    txn(0, 159188, 0, 0, 0);

    model(0, 159188, 0, 68629, ex, ey, ez);
    chk_near("pin_rot30_x", ex, 227023, 16);
    chk_near("pin_rot30_y", ey, 131072, 16);
    txn(0, 159188, 0, 68629, 1);

    model(0, 159188, 0, 308831, ex, ey, ez);
    chk_near("pin_rot135_x", ex, -185364, 16);
    chk_near("pin_rot135_y", ey, 185364, 16);
    txn(0, 159188, 0, 308831, 0);

    model(0, 159188, 0, -308831, ex, ey, ez);
    chk_near("pin_rotm135_x", ex, -185364, 16);
    chk_near("pin_rotm135_y", ey, -185364, 16);
    txn(0, 159188, 0, -308831, 0);

    model(1, 131072, 131072, 0, ex, ey, ez);
    chk_near("pin_vec45_z", ez, 102944, 4);
    chk_near("pin_vec45_x", ex, 305250, 32);
    chk_near("pin_vec45_y", ey, 0, 16);
    txn(1, 131072, 131072, 0, 0);

    model(1, -262144, 0, 0, ex, ey, ez);
    chk_near("pin_vecpi_z", ez, 411775, 4);
    txn(1, -262144, 0, 0, 0);

    txn(1, -100000, -50000, 0, 0);

    model(1, 524287, 524287, 0, ex, ey, ez);
    chk("pin_vecsat_x", ex, 524287);
    txn(1, 524287, 524287, 0, 0);

    model(1, 0, 0, 0, ex, ey, ez);
    chk("pin_vec0_x", ex, 0);
    chk("pin_vec0_y", ey, 0);
    txn(1, 0, 0, 0, 0);

    // Downstream stall in DONE: the checker re-verifies the held result every cycle.
    txn(0, 159188, 0, 68629, 10);

    // A VALID_I pulse while running must not disturb or queue anything.
    accept_txn(0, 159188, 0, 0);
    finish_txn(0, 1'b1);
    repeat (ITER + 4) @(negedge clk);
    chk("no_extra_result", valid_o, 0);
    chk("idle_ready", ready_o, 1);

    // Leave nonzero outputs and MODE_O=1 behind, then reset in the middle of a run.
    txn(1, 131072, 131072, 0, 0);
    accept_txn(0, 159188, 0, 68629);
    repeat (5) @(posedge clk);
    #2;
    exp_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_x_o", x_o, 0);
    chk("midrst_y_o", y_o, 0);
    chk("midrst_z_o", z_o, 0);
    chk("midrst_mode_o", mode_o, 0);
    chk("midrst_ready_o", ready_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", ready_o, 1);
    repeat (ITER + 4) @(negedge clk);
    chk("midrst_no_result", valid_o, 0);

    txn(0, 159188, 0, -68629, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
